// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and types for the PC redirect stage
package pc_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSN_BYTES       = 4;

  // Clearing the two low bits keeps every loaded target word-aligned.
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// rtl/pc_redirect_unit_if.sv - control/target inputs and PC outputs of the redirect stage
interface pc_redirect_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  logic             stall;
  logic             Branch;
  logic             BranchAnd;
  logic             Jump;
  logic [XLEN-1:0]  branch_target;
  logic [XLEN-1:0]  jump_target;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus4;
  logic             redirect;
  logic             flush;
  logic [CNT_W-1:0] br_total;
  logic [CNT_W-1:0] br_taken;

  // Branch control / hazard side.
  modport master (
    output stall, Branch, BranchAnd, Jump, branch_target, jump_target,
    input  pc, pc_plus4, redirect, flush, br_total, br_taken
  );

  // PC stage side.
  modport slave (
    input  stall, Branch, BranchAnd, Jump, branch_target, jump_target,
    output pc, pc_plus4, redirect, flush, br_total, br_taken
  );

endinterface

// File: rtl/flush_sequencer.sv
// rtl/flush_sequencer.sv - flush window FSM with restartable down-counter
module flush_sequencer
  import pc_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic redirect,
  output logic flush
);

  localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  flush_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_q, flush_d;

  // Next state: a redirect always restarts the window; otherwise count down to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    if (redirect && (FLUSH_CYCLES > 0)) begin
      state_d = FLUSH;
      cnt_d   = CW'(FLUSH_CYCLES);
      flush_d = 1'b1;
    end else begin
      case (state_q)
        FLUSH: begin
          if (cnt_q <= CW'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            flush_d = 1'b0;
          end else begin
            cnt_d   = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          flush_d = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered flush output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign flush = flush_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - PC register, redirect select and flush generation (option: PC_REDIRECT_STATS_EN)
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC     = XLEN'(RESET_PC_DEFAULT),
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 32
) (
  input logic               clk,
  input logic               rst,
  pc_redirect_unit_if.slave io
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] align_mask;
  logic            redirect;
  logic            flush;

  // Width-generic form of the alignment mask: only the low two bits are cleared.
  assign align_mask = ~XLEN'(~ALIGN_MASK);
  assign pc_plus4   = pc_q + XLEN'(INSN_BYTES);

  // Next PC: jump wins over taken branch, any redirect wins over stall.
  always_comb begin
    redirect   = io.BranchAnd | io.Jump;
    sel_target = io.Jump ? io.jump_target : io.branch_target;
    pc_d       = pc_plus4;
    if (redirect) begin
      pc_d = sel_target & align_mask;
    end else if (io.stall) begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  flush_sequencer #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_sequencer (
    .clk      (clk),
    .rst      (rst),
    .redirect (redirect),
    .flush    (flush)
  );

  assign io.pc       = pc_q;
  assign io.pc_plus4 = pc_plus4;
  assign io.redirect = redirect;
  assign io.flush    = flush;

`ifdef PC_REDIRECT_STATS_EN
  logic [CNT_W-1:0] br_total_q, br_total_d;
  logic [CNT_W-1:0] br_taken_q, br_taken_d;

  // Saturating counts of unstalled resolved and taken branches.
  always_comb begin
    br_total_d = br_total_q;
    br_taken_d = br_taken_q;
    if (io.Branch && !io.stall && !(&br_total_q)) begin
      br_total_d = br_total_q + CNT_W'(1);
    end
    if (io.BranchAnd && !io.stall && !(&br_taken_q)) begin
      br_taken_d = br_taken_q + CNT_W'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else begin
      br_total_q <= br_total_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign io.br_total = br_total_q;
  assign io.br_taken = br_taken_q;
`else
  // Branch only feeds the statistics, which are absent in this build.
  logic unused_branch;
  assign unused_branch = io.Branch;

  assign io.br_total = '0;
  assign io.br_taken = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - scoreboard bench for pc_redirect_unit
module tb_pc_redirect_unit;

`ifdef PC_REDIRECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        redirect;
    logic [31:0] br_total;
    logic [31:0] br_taken;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   vec_no;
  exp_t sb_q[$];

  pc_redirect_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

  pc_redirect_unit dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] st(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // Apply one cycle of inputs and queue the outputs expected before the next edge.
  task automatic vec(input logic r, input logic s, input logic b, input logic ba,
                     input logic j, input logic [31:0] bt, input logic [31:0] jt,
                     input logic [31:0] epc, input logic [31:0] epc4, input logic ef,
                     input logic ered, input int etot, input int etk);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.stall         = s;
    bus.Branch        = b;
    bus.BranchAnd     = ba;
    bus.Jump          = j;
    bus.branch_target = bt;
    bus.jump_target   = jt;
    vec_no++;
    e.idx      = vec_no;
    e.pc       = epc;
    e.pc_plus4 = epc4;
    e.flush    = ef;
    e.redirect = ered;
    e.br_total = st(etot);
    e.br_taken = st(etk);
    sb_q.push_back(e);
  endtask

  // Monitor: compare the presented outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (bus.pc !== e.pc) begin
        errors++;
        $display("FAIL pc v%0d got %h want %h", e.idx, bus.pc, e.pc);
      end
      checks++;
      if (bus.pc_plus4 !== e.pc_plus4) begin
        errors++;
        $display("FAIL pc_plus4 v%0d got %h want %h", e.idx, bus.pc_plus4, e.pc_plus4);
      end
      checks++;
      if (bus.flush !== e.flush) begin
        errors++;
        $display("FAIL flush v%0d got %b want %b", e.idx, bus.flush, e.flush);
      end
      checks++;
      if (bus.redirect !== e.redirect) begin
        errors++;
        $display("FAIL redirect v%0d got %b want %b", e.idx, bus.redirect, e.redirect);
      end
      checks++;
      if (bus.br_total !== e.br_total) begin
        errors++;
        $display("FAIL br_total v%0d got %0d want %0d", e.idx, bus.br_total, e.br_total);
      end
      checks++;
      if (bus.br_taken !== e.br_taken) begin
        errors++;
        $display("FAIL br_taken v%0d got %0d want %0d", e.idx, bus.br_taken, e.br_taken);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    vec_no = 0;
    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.Branch        = 1'b0;
    bus.BranchAnd     = 1'b0;
    bus.Jump          = 1'b0;
    bus.branch_target = '0;
    bus.jump_target   = '0;
    @(posedge clk);
    //   r s b ba j  bt            jt            pc            pc+4          f  red tot tk
    vec(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0, 0, 0);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0, 0, 0);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0004, 32'h0000_0008, 1'b0, 1'b0, 0, 0);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0008, 32'h0000_000C, 1'b0, 1'b0, 0, 0);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_000C, 32'h0000_0010, 1'b0, 1'b0, 0, 0);
    // Taken branch at 0x10 to 0x40.
    vec(1'b0,1'b0,1'b1,1'b1,1'b0, 32'h40,       32'h0,        32'h0000_0010, 32'h0000_0014, 1'b0, 1'b1, 0, 0);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0040, 32'h0000_0044, 1'b1, 1'b0, 1, 1);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0044, 32'h0000_0048, 1'b1, 1'b0, 1, 1);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0048, 32'h0000_004C, 1'b0, 1'b0, 1, 1);
    // Jump and taken branch together: jump target wins, low bits cleared.
    vec(1'b0,1'b0,1'b1,1'b1,1'b1, 32'h200,      32'h103,      32'h0000_004C, 32'h0000_0050, 1'b0, 1'b1, 1, 1);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0100, 32'h0000_0104, 1'b1, 1'b0, 2, 2);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0104, 32'h0000_0108, 1'b1, 1'b0, 2, 2);
    // Jump to 0x20, then stall there; flush still counts down under stall.
    vec(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,        32'h20,       32'h0000_0108, 32'h0000_010C, 1'b0, 1'b1, 2, 2);
    vec(1'b0,1'b1,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0020, 32'h0000_0024, 1'b1, 1'b0, 2, 2);
    vec(1'b0,1'b1,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0020, 32'h0000_0024, 1'b1, 1'b0, 2, 2);
    // Redirect raised during stall: loads target; stalled branch not counted.
    vec(1'b0,1'b1,1'b1,1'b1,1'b0, 32'h80,       32'h0,        32'h0000_0020, 32'h0000_0024, 1'b0, 1'b1, 2, 2);
    // Second redirect one cycle into the window restarts it.
    vec(1'b0,1'b0,1'b1,1'b1,1'b0, 32'h300,      32'h0,        32'h0000_0080, 32'h0000_0084, 1'b1, 1'b1, 2, 2);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0300, 32'h0000_0304, 1'b1, 1'b0, 3, 3);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0304, 32'h0000_0308, 1'b1, 1'b0, 3, 3);
    // Jump to top of address space, then wrap.
    vec(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,        32'hFFFF_FFFF, 32'h0000_0308, 32'h0000_030C, 1'b0, 1'b1, 3, 3);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0, 3, 3);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0000, 32'h0000_0004, 1'b1, 1'b0, 3, 3);
    // Not-taken branch: counted in total only, no redirect.
    vec(1'b0,1'b0,1'b1,1'b0,1'b0, 32'h600,      32'h0,        32'h0000_0004, 32'h0000_0008, 1'b0, 1'b0, 3, 3);
    vec(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,        32'h500,      32'h0000_0008, 32'h0000_000C, 1'b0, 1'b1, 4, 3);
    // Reset mid-flush.
    vec(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0500, 32'h0000_0504, 1'b1, 1'b0, 4, 3);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0, 0, 0);
    vec(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h0000_0004, 32'h0000_0008, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (sb_q.size() != 0) @(posedge clk);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
